// File: rtl/fir_driver.sv
// Host-side controller for the serial-coefficient symmetric FIR core: shifts a
// coefficient set into the core, then sequences one sample per operation.
module fir_driver #(
   parameter int BITS    = 8,
   parameter int NCOEF   = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_load,
   input  logic [NCOEF*BITS-1:0]   cfg_coeffs,
   output logic                    cfg_busy,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [BITS-1:0]         s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [BITS-1:0]         m_data,
   output logic                    err,
   output logic                    coeff_load_in,
   output logic                    coeff_in,
   output logic                    lock,
   output logic                    start,
   output logic [BITS-1:0]         x,
   input  logic                    done,
   input  logic [BITS-1:0]         y
);

   localparam int NB  = NCOEF * BITS;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int TCW = $clog2(TIMEOUT + 1);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(NB - 1);
   localparam logic [TCW-1:0] TMO      = TCW'(TIMEOUT);

   typedef enum logic [2:0] {
      UNCFG = 3'd0,
      SHIFT = 3'd1,
      IDLE  = 3'd2,
      ISSUE = 3'd3,
      WAIT  = 3'd4,
      OUT   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [NB-1:0]     shreg_q, shreg_d;
   logic [BCW-1:0]    bitcnt_q, bitcnt_d;
   logic [TCW-1:0]    tcnt_q, tcnt_d;
   logic              load_q, load_d;
   logic              lock_q, lock_d;
   logic              start_q, start_d;
   logic [BITS-1:0]   x_q, x_d;
   logic              m_valid_q, m_valid_d;
   logic [BITS-1:0]   m_data_q, m_data_d;
   logic              err_q, err_d;
   logic              s_ready_s;

   // Next-state and next-output logic for the operation sequencer.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bitcnt_d  = bitcnt_q;
      tcnt_d    = tcnt_q;
      load_d    = load_q;
      lock_d    = lock_q;
      start_d   = 1'b0;
      x_d       = x_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      err_d     = err_q;
      s_ready_s = 1'b0;

      case (state_q)
         UNCFG: begin
            if (cfg_load) begin
               state_d  = SHIFT;
               shreg_d  = cfg_coeffs;
               bitcnt_d = '0;
               load_d   = 1'b1;
               lock_d   = 1'b0;
               err_d    = 1'b0;
            end else begin
               state_d = UNCFG;
            end
         end
         SHIFT: begin
            shreg_d = {shreg_q[NB-2:0], 1'b0};
            if (bitcnt_q == LAST_BIT) begin
               bitcnt_d = '0;
               load_d   = 1'b0;
               lock_d   = 1'b1;
               state_d  = IDLE;
            end else begin
               bitcnt_d = bitcnt_q + BCW'(1);
            end
         end
         IDLE: begin
            // cfg_load outranks a pending sample, so the sample is refused.
            s_ready_s = ~cfg_load;
            if (cfg_load) begin
               state_d  = SHIFT;
               shreg_d  = cfg_coeffs;
               bitcnt_d = '0;
               load_d   = 1'b1;
               lock_d   = 1'b0;
               err_d    = 1'b0;
            end else if (s_valid) begin
               x_d     = s_data;
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            start_d = 1'b1;
            tcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done landing on the last allowed count still wins over timeout.
            if (done) begin
               m_data_d  = y;
               m_valid_d = 1'b1;
               state_d   = OUT;
            end else if (tcnt_q == TMO) begin
               err_d     = 1'b1;
               m_data_d  = '0;
               m_valid_d = 1'b1;
               state_d   = OUT;
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end else begin
               m_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = UNCFG;
            load_d  = 1'b0;
            lock_d  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= UNCFG;
         shreg_q   <= '0;
         bitcnt_q  <= '0;
         tcnt_q    <= '0;
         load_q    <= 1'b0;
         lock_q    <= 1'b0;
         start_q   <= 1'b0;
         x_q       <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         tcnt_q    <= tcnt_d;
         load_q    <= load_d;
         lock_q    <= lock_d;
         start_q   <= start_d;
         x_q       <= x_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end

   assign cfg_busy      = load_q;
   assign coeff_load_in = load_q;
   assign coeff_in      = shreg_q[NB-1] & load_q;
   assign lock          = lock_q;
   assign start         = start_q;
   assign x             = x_q;
   assign m_valid       = m_valid_q;
   assign m_data        = m_data_q;
   assign err           = err_q;
   assign s_ready       = s_ready_s;

endmodule
